instruction_decode: RTL and testbench
=====================================

# instruction_decode

Second pipeline stage of the 32-bit RISC core. Takes `instruction`/`pc_current` from `instruction_fetch` and decodes the fields. Reads the integrated 32x32 register file and registers an ID/EX bundle for execute. It resolves branches and jumps, and drives `isbranchtaken`/`branchpc` back to fetch, squashing the one wrong-path instruction that follows a redirect.

## Interface
- `RESET_PC`, 32'h0000_0000: `ex_pc` value after reset
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `instruction`  in  32  instruction from fetch
- `pc_current`  in  32  address of `instruction`
- `if_valid`  in  1  `instruction` is meaningful this cycle
- `stall`  in  1  hold all stage state (from execute/memory)
- `wb_en`, `wb_rd[4:0]`, `wb_data[31:0]`  in  1/5/32  register-file write port
- `ex_valid`  out  1  ID/EX bundle holds a live instruction
- `ex_alu_op`  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT
- `ex_a`, `ex_b`, `ex_store_data`  out  32  rs1 value, rs2 value or sext(imm16), reg[rd] for SW
- `ex_rd`  out  5  destination register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1 each  control
- `ex_pc`  out  32  pc of bundle
- `isbranchtaken`  out  1  redirect fetch
- `branchpc`  out  32  redirect target
- `halted`, `illegal`  out  1 each  sticky HALT seen; pulse on bad opcode

## Operation
- Fields:
  - op = [31:26], rd = [25:21], rs1 = [20:16], rs2 = [15:11]
  - imm16 = [15:0], imm26 = [25:0]
  - sext = sign-extend to 32
- Opcodes:
  - 00–05: R-type ALU, rd <- rs1 op rs2
  - 08: ADDI
  - 10: LW rd <- mem[rs1 + sext(imm16)]
  - 11: SW mem[rs1 + sext(imm16)] <- reg[rd]
  - 20: BEQ (reg[rd] == reg[rs1])
  - 21: BNE
  - 30: JMP
  - 3F: HALT
- Branch/jump target:
  - BEQ/BNE: pc_current + 4 + (sext(imm16) << 2)
  - JMP: pc_current + 4 + (sext(imm26) << 2)
  - 32-bit modulo wrap.
- Branches, jumps and HALT have `ex_reg_write` = `ex_mem_read` = `ex_mem_write` = 0.
- Undefined opcode:
  - Emitted as a bubble (`ex_valid` = 0).
  - `illegal` = 1 for that one cycle.
- Register file:
  - r0 reads 0; writes to r0 are ignored.
  - A write with `wb_en` lands at the posedge.
  - Reset clears all 32 entries.
- Stage state machine, states RUN, SQUASH, HALT:
  - RUN: on an accepted taken branch/JMP, go to SQUASH; on accepted HALT, go to HALT.
  - SQUASH: the next accepted instruction is dropped (`ex_valid` = 0), then return to RUN.
  - HALT: `ex_valid` = 0 forever, `halted` = 1; only `rst` exits.
- Accept = posedge with `if_valid` = 1, `stall` = 0, state != HALT.

## Timing
- Latency: one cycle. The instruction sampled at posedge N appears on `ex_*` after edge N.
- Branch redirect timing:
  - `isbranchtaken`/`branchpc` are registered at the same edge N.
  - `isbranchtaken` is high for exactly one unstalled cycle.
- `if_valid` = 0 with `stall` = 0: bubble (`ex_valid` = 0); the SQUASH state is retained.
- `stall` = 1:
  - Every registered output and the state hold, including `isbranchtaken`.
  - Register-file writes still occur.
- A taken branch in the SQUASH slot is itself squashed and causes no redirect.
- Read-during-write of the same register: old value, unless DECODE_BYPASS_EN.
- Reset values:
  - `ex_valid` 0, `ex_pc` RESET_PC, `isbranchtaken` 0, `branchpc` 0, `halted` 0, `illegal` 0.
  - All other `ex_*` 0; state RUN.
- `rst` mid-branch or mid-stall: reset wins, and the pending squash is cancelled.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - A read of register r (r != 0) in the same cycle as `wb_en` with `wb_rd` == r returns `wb_data`.
  - Applies to `ex_a`, `ex_b`, `ex_store_data` and the branch compare.
- Not defined: the same read returns the pre-write contents.

## Test plan
- Reset, then ADDI r1, r0, 0x7FFF at pc 0 → `ex_valid` 1, `ex_a` 0, `ex_b` 32'h0000_7FFF, `ex_rd` 1, `ex_reg_write` 1, `ex_pc` 0.
- Preload r2 = 5 and r3 = 5 via wb; BEQ rd = 2, rs1 = 3, imm16 = 16'hFFFF at pc 0x40 → `isbranchtaken` 1 for 1 cycle, `branchpc` 0x40; next instruction gives `ex_valid` 0.
- Same setup with BNE → `isbranchtaken` 0; next instruction passes with `ex_valid` 1.
- Same-cycle `wb_en` to r4 = 0xDEAD with ADD r5, r4, r0 → `ex_a` 0xDEAD with the macro defined, 0 without.
- `stall` high for 3 cycles right after a taken JMP → `isbranchtaken` held high through the stall, then one more cycle, then squash.
- HALT then three ALU ops → `halted` 1 and `ex_valid` 0 throughout; opcode 6'h2A → `illegal` pulses for 1 cycle; `rst` clears `halted`.

Source files
------------

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage of the 32-bit RISC core -- field decode, 32x32 register file,
// branch/jump resolution with one-slot squash. Optional same-cycle write bypass: DECODE_BYPASS_EN.
module instruction_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] pc_current,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_pc,
  output logic        isbranchtaken,
  output logic [31:0] branchpc,
  output logic        halted,
  output logic        illegal
);

  localparam logic [5:0] OP_ALU_MAX = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h10;
  localparam logic [5:0] OP_SW      = 6'h11;
  localparam logic [5:0] OP_BEQ     = 6'h20;
  localparam logic [5:0] OP_BNE     = 6'h21;
  localparam logic [5:0] OP_JMP     = 6'h30;
  localparam logic [5:0] OP_HALT    = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t state_p1;
  state_t state_next;

  logic [31:0] regs [32];

  // Register read with an optional forward of the write port landing this same edge.
  function automatic logic [31:0] read_port(
    input logic [4:0]  idx,
    input logic [31:0] stored,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    logic [31:0] val;
    val = stored;
`ifdef DECODE_BYPASS_EN
    if (we && (wa == idx)) val = wd;
`else
    if (we && (wa == idx) && 1'b0) val = wd;
`endif
    if (idx == 5'd0) val = 32'd0;
    return val;
  endfunction

  // ---- p0: field decode and operand read ----
  logic [5:0]  op_p0;
  logic [4:0]  rd_p0;
  logic [4:0]  rs1_p0;
  logic [4:0]  rs2_p0;
  logic [31:0] rs1_val_p0;
  logic [31:0] rs2_val_p0;
  logic [31:0] rd_val_p0;

  assign op_p0  = instruction[31:26];
  assign rd_p0  = instruction[25:21];
  assign rs1_p0 = instruction[20:16];
  assign rs2_p0 = instruction[15:11];

  assign rs1_val_p0 = read_port(rs1_p0, regs[rs1_p0], wb_en, wb_rd, wb_data);
  assign rs2_val_p0 = read_port(rs2_p0, regs[rs2_p0], wb_en, wb_rd, wb_data);
  assign rd_val_p0  = read_port(rd_p0,  regs[rd_p0],  wb_en, wb_rd, wb_data);

  logic is_alu_p0, is_addi_p0, is_lw_p0, is_sw_p0;
  logic is_beq_p0, is_bne_p0, is_jmp_p0, is_halt_p0;
  logic legal_p0, equal_p0, taken_p0;

  assign is_alu_p0  = (op_p0 <= OP_ALU_MAX);
  assign is_addi_p0 = (op_p0 == OP_ADDI);
  assign is_lw_p0   = (op_p0 == OP_LW);
  assign is_sw_p0   = (op_p0 == OP_SW);
  assign is_beq_p0  = (op_p0 == OP_BEQ);
  assign is_bne_p0  = (op_p0 == OP_BNE);
  assign is_jmp_p0  = (op_p0 == OP_JMP);
  assign is_halt_p0 = (op_p0 == OP_HALT);
  assign legal_p0   = is_alu_p0 | is_addi_p0 | is_lw_p0 | is_sw_p0 |
                      is_beq_p0 | is_bne_p0 | is_jmp_p0 | is_halt_p0;

  assign equal_p0 = (rd_val_p0 == rs1_val_p0);
  assign taken_p0 = is_jmp_p0 | (is_beq_p0 & equal_p0) | (is_bne_p0 & ~equal_p0);

  logic signed [31:0] imm16_p0;
  logic signed [31:0] imm26_p0;
  logic signed [31:0] offset_p0;
  logic [31:0]        target_p0;

  assign imm16_p0  = {{16{instruction[15]}}, instruction[15:0]};
  assign imm26_p0  = {{6{instruction[25]}}, instruction[25:0]};
  assign offset_p0 = (is_jmp_p0 ? imm26_p0 : imm16_p0) <<< 2;
  assign target_p0 = pc_current + 32'd4 + $unsigned(offset_p0);

  logic [3:0]  alu_op_p0;
  logic [31:0] b_val_p0;
  logic        reg_write_p0;

  assign alu_op_p0    = is_alu_p0 ? op_p0[3:0] : 4'd0;
  assign b_val_p0     = is_alu_p0 ? rs2_val_p0 : $unsigned(imm16_p0);
  assign reg_write_p0 = is_alu_p0 | is_addi_p0 | is_lw_p0;

  // Stage FSM: decides whether this cycle's instruction is emitted, squashed or halts the stage.
  logic accept_p0;
  logic emit_p0;
  logic redirect_p0;
  logic go_halt_p0;
  logic flag_illegal_p0;

  assign accept_p0 = if_valid & ~stall & (state_p1 != ST_HALT);

  always_comb begin
    state_next      = state_p1;
    emit_p0         = 1'b0;
    redirect_p0     = 1'b0;
    go_halt_p0      = 1'b0;
    flag_illegal_p0 = 1'b0;
    case (state_p1)
      ST_RUN: begin
        if (accept_p0) begin
          if (!legal_p0) begin
            flag_illegal_p0 = 1'b1;
          end else if (is_halt_p0) begin
            go_halt_p0 = 1'b1;
            state_next = ST_HALT;
          end else begin
            emit_p0 = 1'b1;
            if (taken_p0) begin
              redirect_p0 = 1'b1;
              state_next  = ST_SQUASH;
            end
          end
        end
      end
      ST_SQUASH: begin
        if (accept_p0) state_next = ST_RUN;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // ---- p1: ID/EX control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1      <= ST_RUN;
      ex_valid      <= 1'b0;
      isbranchtaken <= 1'b0;
      branchpc      <= 32'd0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
    end else if (!stall) begin
      state_p1      <= state_next;
      ex_valid      <= emit_p0;
      isbranchtaken <= redirect_p0;
      illegal       <= flag_illegal_p0;
      if (go_halt_p0)  halted   <= 1'b1;
      if (redirect_p0) branchpc <= target_p0;
    end
  end

  // ---- p1: ID/EX data registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_alu_op     <= 4'd0;
      ex_a          <= 32'd0;
      ex_b          <= 32'd0;
      ex_store_data <= 32'd0;
      ex_rd         <= 5'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_pc         <= RESET_PC;
    end else if (emit_p0) begin
      ex_alu_op     <= alu_op_p0;
      ex_a          <= rs1_val_p0;
      ex_b          <= b_val_p0;
      ex_store_data <= rd_val_p0;
      ex_rd         <= rd_p0;
      ex_reg_write  <= reg_write_p0;
      ex_mem_read   <= is_lw_p0;
      ex_mem_write  <= is_sw_p0;
      ex_pc         <= pc_current;
    end
  end

  // Register file writes are independent of stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed table, corner sequences, and a
// randomized run against a behavioural model. Honors DECODE_BYPASS_EN when defined.
module tb_instruction_decode;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] pc_current;
  logic        if_valid;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc, branchpc;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        isbranchtaken, halted, illegal;

  instruction_decode #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pc_current(pc_current),
    .if_valid(if_valid), .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc(ex_pc),
    .isbranchtaken(isbranchtaken), .branchpc(branchpc), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] imm);
    return {op, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_valid = 1'b0; stall = 1'b0; wb_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    instruction = ins; pc_current = pc; if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
  endtask

  task automatic preload();
    wb_write(5'd2, 32'd5);
    wb_write(5'd3, 32'd5);
    wb_write(5'd7, 32'hFFFF_FFFD);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        chk_data;
    logic [3:0]  alu;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, tk;
    logic [31:0] bpc;
    logic        ill, hlt;
  } vec_t;

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] pc,
                               input logic valid, input logic chk_data, input logic [3:0] alu,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic tk, input logic [31:0] bpc,
                               input logic ill, input logic hlt);
    vec_t v;
    v.instr = instr; v.pc = pc; v.valid = valid; v.chk_data = chk_data; v.alu = alu;
    v.a = a; v.b = b; v.sd = sd; v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw;
    v.tk = tk; v.bpc = bpc; v.ill = ill; v.hlt = hlt;
    return v;
  endfunction

  // Behavioural model state for the random phase.
  logic [31:0] mregs [32];
  logic        m_squash, m_halted;
  logic        e_valid, e_br, e_rw, e_mr, e_mw, e_tk, e_ill;
  logic [3:0]  e_alu;
  logic [31:0] e_a, e_b, e_sd, e_pc, e_bpc;
  logic [4:0]  e_rd;

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef DECODE_BYPASS_EN
    if (wb_en && wb_rd == r) return wb_data;
`endif
    return mregs[r];
  endfunction

  task automatic model_step();
    logic [5:0]  op;
    logic [31:0] ra, rb, rdv, s16, s26;
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      m_squash = 1'b0; m_halted = 1'b0;
      e_valid = 1'b0; e_tk = 1'b0; e_bpc = 32'd0; e_ill = 1'b0; e_pc = 32'd0;
      return;
    end
    if (!stall) begin
      e_valid = 1'b0; e_tk = 1'b0; e_ill = 1'b0;
      if (if_valid && !m_halted) begin
        if (m_squash) begin
          m_squash = 1'b0;
        end else begin
          op  = instruction[31:26];
          ra  = mread(instruction[20:16]);
          rb  = mread(instruction[15:11]);
          rdv = mread(instruction[25:21]);
          s16 = {16'd0, instruction[15:0]} - (instruction[15] ? 32'h0001_0000 : 32'd0);
          s26 = {6'd0, instruction[25:0]} - (instruction[25] ? 32'h0400_0000 : 32'd0);
          e_rw = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_br = 1'b0;
          e_pc = pc_current; e_rd = instruction[25:21]; e_sd = rdv; e_a = ra; e_alu = 4'd0;
          if (op <= 6'd5) begin
            e_valid = 1'b1; e_alu = op[3:0]; e_b = rb; e_rw = 1'b1;
          end else begin
            case (op)
              6'h08: begin e_valid = 1'b1; e_b = s16; e_rw = 1'b1; end
              6'h10: begin e_valid = 1'b1; e_b = s16; e_rw = 1'b1; e_mr = 1'b1; end
              6'h11: begin e_valid = 1'b1; e_b = s16; e_mw = 1'b1; end
              6'h20, 6'h21, 6'h30: begin
                e_valid = 1'b1; e_br = 1'b1;
                if (op == 6'h30 || (op == 6'h20) == (rdv == ra)) begin
                  e_tk = 1'b1; m_squash = 1'b1;
                  e_bpc = pc_current + 32'd4 + ((op == 6'h30 ? s26 : s16) * 32'd4);
                end
              end
              6'h3F: m_halted = 1'b1;
              default: e_ill = 1'b1;
            endcase
          end
        end
      end
    end
    if (wb_en && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0, 1, 2, 3, 4, 5: return enc_r(6'($urandom_range(0, 5)), a, b, c);
      6:  return enc_i(6'h08, a, b, 16'($urandom));
      7:  return enc_i(6'h10, a, b, 16'($urandom));
      8:  return enc_i(6'h11, a, b, 16'($urandom));
      9:  return enc_i(6'h20, a, b, 16'($urandom));
      10: return enc_i(6'h21, a, b, 16'($urandom));
      11: return enc_j(6'h30, 26'($urandom));
      12: return ($urandom_range(0, 9) == 0) ? enc_j(6'h3F, 26'd0) : enc_i(6'h08, a, b, 16'd1);
      default: return enc_j(($urandom_range(0, 1) == 0) ? 6'h2A : 6'h09, 26'($urandom));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t vt [15];

  initial begin
    rst = 1'b0; instruction = 32'd0; pc_current = 32'd0; if_valid = 1'b0;
    stall = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

    vt[0]  = mkv(enc_i(6'h08, 5'd1, 5'd0, 16'h7FFF), 32'h0, 1, 1, 4'd0, 32'd0, 32'h7FFF, 32'd0, 5'd1, 1, 0, 0, 0, 32'd0, 0, 0);
    vt[1]  = mkv(enc_r(6'h00, 5'd5, 5'd2, 5'd7), 32'h10, 1, 1, 4'd0, 32'd5, 32'hFFFF_FFFD, 32'd0, 5'd5, 1, 0, 0, 0, 32'd0, 0, 0);
    vt[2]  = mkv(enc_r(6'h01, 5'd6, 5'd3, 5'd2), 32'h14, 1, 1, 4'd1, 32'd5, 32'd5, 32'd0, 5'd6, 1, 0, 0, 0, 32'd0, 0, 0);
    vt[3]  = mkv(enc_r(6'h05, 5'd1, 5'd7, 5'd2), 32'h18, 1, 1, 4'd5, 32'hFFFF_FFFD, 32'd5, 32'd0, 5'd1, 1, 0, 0, 0, 32'd0, 0, 0);
    vt[4]  = mkv(enc_i(6'h08, 5'd8, 5'd2, 16'h8000), 32'h1C, 1, 1, 4'd0, 32'd5, 32'hFFFF_8000, 32'd0, 5'd8, 1, 0, 0, 0, 32'd0, 0, 0);
    vt[5]  = mkv(enc_i(6'h10, 5'd9, 5'd3, 16'hFFFC), 32'h20, 1, 1, 4'd0, 32'd5, 32'hFFFF_FFFC, 32'd0, 5'd9, 1, 1, 0, 0, 32'd0, 0, 0);
    vt[6]  = mkv(enc_i(6'h11, 5'd7, 5'd2, 16'h0004), 32'h24, 1, 1, 4'd0, 32'd5, 32'd4, 32'hFFFF_FFFD, 5'd7, 0, 0, 1, 0, 32'd0, 0, 0);
    vt[7]  = mkv(enc_i(6'h20, 5'd2, 5'd3, 16'hFFFF), 32'h40, 1, 0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1, 32'h40, 0, 0);
    vt[8]  = mkv(enc_i(6'h21, 5'd2, 5'd3, 16'hFFFF), 32'h40, 1, 0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 32'd0, 0, 0);
    vt[9]  = mkv(enc_j(6'h30, 26'h10), 32'hFFFF_FFF0, 1, 0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1, 32'h34, 0, 0);
    vt[10] = mkv(enc_i(6'h20, 5'd2, 5'd7, 16'h0008), 32'h80, 1, 0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 32'd0, 0, 0);
    vt[11] = mkv(enc_j(6'h2A, 26'd0), 32'h0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 32'd0, 1, 0);
    vt[12] = mkv(enc_j(6'h3F, 26'd0), 32'h0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 32'd0, 0, 1);
    vt[13] = mkv(enc_r(6'h04, 5'd10, 5'd7, 5'd7), 32'h28, 1, 1, 4'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd0, 5'd10, 1, 0, 0, 0, 32'd0, 0, 0);
    vt[14] = mkv(enc_i(6'h21, 5'd2, 5'd7, 16'h0002), 32'h200, 1, 0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1, 32'h20C, 0, 0);

    // Reset state after live activity
    do_reset();
    issue(enc_j(6'h30, 26'h5), 32'h400);
    wb_write(5'd1, 32'h1234);
    do_reset();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_taken", 32'(isbranchtaken), 32'd0);
    chk("rst_branchpc", branchpc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_ex_a", ex_a, 32'd0);
    chk("rst_reg_write", 32'(ex_reg_write), 32'd0);
    issue(enc_r(6'h00, 5'd2, 5'd1, 5'd0), 32'h8);
    chk("rst_regfile_cleared", ex_a, 32'd0);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      do_reset();
      preload();
      issue(vt[i].instr, vt[i].pc);
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(vt[i].valid));
      chk($sformatf("v%0d_taken", i), 32'(isbranchtaken), 32'(vt[i].tk));
      chk($sformatf("v%0d_branchpc", i), branchpc, vt[i].bpc);
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vt[i].ill));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vt[i].hlt));
      if (vt[i].valid) begin
        chk($sformatf("v%0d_pc", i), ex_pc, vt[i].pc);
        chk($sformatf("v%0d_rw", i), 32'(ex_reg_write), 32'(vt[i].rw));
        chk($sformatf("v%0d_mr", i), 32'(ex_mem_read), 32'(vt[i].mr));
        chk($sformatf("v%0d_mw", i), 32'(ex_mem_write), 32'(vt[i].mw));
      end
      if (vt[i].chk_data) begin
        chk($sformatf("v%0d_alu", i), 32'(ex_alu_op), 32'(vt[i].alu));
        chk($sformatf("v%0d_a", i), ex_a, vt[i].a);
        chk($sformatf("v%0d_b", i), ex_b, vt[i].b);
        chk($sformatf("v%0d_sd", i), ex_store_data, vt[i].sd);
        if (vt[i].rw) chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vt[i].rd));
      end
    end

    // Taken BEQ: one-cycle redirect, next instruction squashed, following one passes
    do_reset(); preload();
    issue(enc_i(6'h20, 5'd2, 5'd3, 16'hFFFF), 32'h40);
    chk("beq_taken", 32'(isbranchtaken), 32'd1);
    issue(enc_i(6'h08, 5'd1, 5'd0, 16'h1), 32'h44);
    chk("beq_taken_drop", 32'(isbranchtaken), 32'd0);
    chk("beq_squash_valid", 32'(ex_valid), 32'd0);
    issue(enc_i(6'h08, 5'd1, 5'd0, 16'h1), 32'h48);
    chk("beq_after_valid", 32'(ex_valid), 32'd1);
    chk("beq_after_pc", ex_pc, 32'h48);

    // BNE not taken: next passes
    do_reset(); preload();
    issue(enc_i(6'h21, 5'd2, 5'd3, 16'hFFFF), 32'h40);
    issue(enc_i(6'h08, 5'd1, 5'd0, 16'h1), 32'h44);
    chk("bne_next_valid", 32'(ex_valid), 32'd1);
    chk("bne_next_pc", ex_pc, 32'h44);

    // Same-cycle write and read of r4
    do_reset();
    wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_DEAD;
    issue(enc_r(6'h00, 5'd5, 5'd4, 5'd0), 32'h0);
    wb_en = 1'b0;
`ifdef DECODE_BYPASS_EN
    chk("bypass_ex_a", ex_a, 32'h0000_DEAD);
`else
    chk("bypass_ex_a", ex_a, 32'h0);
`endif
    issue(enc_r(6'h00, 5'd5, 5'd4, 5'd0), 32'h4);
    chk("after_write_ex_a", ex_a, 32'h0000_DEAD);

    // Stall for three cycles right after a taken JMP
    do_reset();
    issue(enc_j(6'h30, 26'd0), 32'h100);
    chk("jmp_taken", 32'(isbranchtaken), 32'd1);
    chk("jmp_target", branchpc, 32'h104);
    instruction = enc_i(6'h08, 5'd1, 5'd0, 16'h2); pc_current = 32'h104;
    if_valid = 1'b1; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_taken", k), 32'(isbranchtaken), 32'd1);
      chk($sformatf("stall%0d_valid", k), 32'(ex_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("stall_rel_taken", 32'(isbranchtaken), 32'd0);
    chk("stall_rel_squash", 32'(ex_valid), 32'd0);
    tick();
    if_valid = 1'b0;
    chk("stall_rel_next", 32'(ex_valid), 32'd1);

    // Bubble while in SQUASH keeps the squash pending
    do_reset();
    issue(enc_j(6'h30, 26'd4), 32'h0);
    tick();
    chk("sq_bubble_valid", 32'(ex_valid), 32'd0);
    issue(enc_i(6'h08, 5'd1, 5'd0, 16'h3), 32'h14);
    chk("sq_retained_drop", 32'(ex_valid), 32'd0);
    issue(enc_i(6'h08, 5'd1, 5'd0, 16'h3), 32'h18);
    chk("sq_then_pass", 32'(ex_valid), 32'd1);

    // Reset during pending squash cancels it
    do_reset();
    issue(enc_j(6'h30, 26'd4), 32'h0);
    do_reset();
    issue(enc_i(6'h08, 5'd1, 5'd0, 16'h3), 32'h4);
    chk("rst_cancels_squash", 32'(ex_valid), 32'd1);

    // HALT then ALU ops; reset exits; illegal pulse
    do_reset();
    issue(enc_j(6'h3F, 26'd0), 32'h0);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_valid", 32'(ex_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      issue(enc_r(6'h00, 5'd1, 5'd0, 5'd0), 32'h4 + 32'(k * 4));
      chk($sformatf("halt_alu%0d_valid", k), 32'(ex_valid), 32'd0);
      chk($sformatf("halt_alu%0d_halted", k), 32'(halted), 32'd1);
    end
    do_reset();
    chk("halt_rst_clears", 32'(halted), 32'd0);
    issue(enc_j(6'h2A, 26'd0), 32'h0);
    chk("illegal_pulse", 32'(illegal), 32'd1);
    chk("illegal_bubble", 32'(ex_valid), 32'd0);
    tick();
    chk("illegal_clears", 32'(illegal), 32'd0);

    // Randomized run against the model
    rst = 1'b1; if_valid = 1'b0; stall = 1'b0; wb_en = 1'b0;
    model_step();
    tick();
    for (int n = 0; n < 700; n++) begin
      rst         = ($urandom_range(0, 59) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      if_valid    = ($urandom_range(0, 3) != 0);
      wb_en       = ($urandom_range(0, 1) == 0);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = ($urandom_range(0, 2) == 0) ? 32'd5 : $urandom;
      instruction = rand_instr();
      pc_current  = $urandom & 32'hFFFF_FFFC;
      model_step();
      tick();
      chk("r_valid", 32'(ex_valid), 32'(e_valid));
      chk("r_taken", 32'(isbranchtaken), 32'(e_tk));
      chk("r_branchpc", branchpc, e_bpc);
      chk("r_illegal", 32'(illegal), 32'(e_ill));
      chk("r_halted", 32'(halted), 32'(m_halted));
      if (e_valid) begin
        chk("r_pc", ex_pc, e_pc);
        chk("r_rw", 32'(ex_reg_write), 32'(e_rw));
        chk("r_mr", 32'(ex_mem_read), 32'(e_mr));
        chk("r_mw", 32'(ex_mem_write), 32'(e_mw));
        if (!e_br) begin
          chk("r_alu", 32'(ex_alu_op), 32'(e_alu));
          chk("r_a", ex_a, e_a);
          chk("r_b", ex_b, e_b);
          chk("r_sd", ex_store_data, e_sd);
          if (e_rw) chk("r_rd", 32'(ex_rd), 32'(e_rd));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
